// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port pixel RAM between display scan-out
// reads and posted CPU pixel writes, with a starvation bound for the CPU side.
module vga_fb_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            disp_req,
    input  logic [ADDR_WIDTH-1:0]           disp_addr,
    output logic                            disp_ack,
    output logic [DATA_WIDTH-1:0]           disp_rdata,
    output logic                            disp_rvalid,
    input  logic                            cpu_wvalid,
    input  logic [ADDR_WIDTH-1:0]           cpu_waddr,
    input  logic [DATA_WIDTH-1:0]           cpu_wdata,
    output logic                            cpu_wready,
    output logic [$clog2(WBUF_DEPTH):0]     wbuf_level,
    output logic                            ram_en,
    output logic                            ram_we,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_wdata,
    input  logic [DATA_WIDTH-1:0]           ram_rdata,
    output logic [7:0]                      dbg_starve_cnt
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);

    logic [PTR_W:0]          wr_ptr;
    logic [PTR_W:0]          rd_ptr;
    logic [ADDR_WIDTH-1:0]   wbuf_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   wbuf_data [WBUF_DEPTH];
    logic [7:0]              starve_cnt;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    cpu_grant;
    logic                    rd_p1;
    logic                    rd_p2;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Handshakes: a write is pushed when cpu_wvalid && cpu_wready; a fetch is
    // accepted when disp_req && disp_ack. Both readies are forced low in reset.
    assign cpu_wready = S_AXI_ARESETN && !fifo_full;
    assign push       = cpu_wvalid && cpu_wready;
    assign disp_ack   = S_AXI_ARESETN && disp_req &&
                        (fifo_empty || (starve_cnt < 8'(STARVE_LIMIT)));
    assign cpu_grant  = S_AXI_ARESETN && !disp_ack && !fifo_empty;

    assign wbuf_level     = wr_ptr - rd_ptr;
    assign dbg_starve_cnt = starve_cnt;

    // Storage needs no reset: stale words are unreachable once the pointers clear.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            wbuf_addr[wr_ptr[PTR_W-1:0]] <= cpu_waddr;
            wbuf_data[wr_ptr[PTR_W-1:0]] <= cpu_wdata;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            starve_cnt  <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            rd_p1       <= 1'b0;
            rd_p2       <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (cpu_grant)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);

            if (fifo_empty || cpu_grant)
                starve_cnt <= '0;
            else if (disp_ack && (starve_cnt < 8'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 8'd1;

            ram_en <= disp_ack || cpu_grant;
            ram_we <= cpu_grant;
            if (disp_ack) begin
                ram_addr <= disp_addr;
            end else if (cpu_grant) begin
                ram_addr  <= wbuf_addr[rd_ptr[PTR_W-1:0]];
                ram_wdata <= wbuf_data[rd_ptr[PTR_W-1:0]];
            end

            // Read pipeline: RAM access, RAM data out, then registered to the display.
            rd_p1       <= disp_ack;
            rd_p2       <= rd_p1;
            disp_rvalid <= rd_p2;
            if (rd_p2)
                disp_rdata <= ram_rdata;
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer arbiter for the VGA IP. It shares one pixel RAM between the display scan-out fetcher and CPU pixel writes arriving from the AXI4-Lite slave logic. CPU writes go through a small posted-write FIFO. The display wins by default; a starvation counter guarantees the CPU a slot after a bounded number of consecutive display grants. It sits between the AXI slave/user-logic register file and the RGB565 pixel RAM, all in the S_AXI_ACLK domain.

## Interface
Parameters:
- ADDR_WIDTH, 16, pixel RAM word address width
- DATA_WIDTH, 16, pixel width (RGB565: r[15:11], g[10:5], b[4:0])
- WBUF_DEPTH, 4, write FIFO entries; power of two, at least 2
- STARVE_LIMIT, 8, consecutive display grants allowed while the FIFO is non-empty; range 1..255

Ports:
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- disp_req  in  1  display fetch request; held with disp_addr stable until accepted
- disp_addr  in  ADDR_WIDTH  display read address
- disp_ack  out  1  combinational grant; disp_req && disp_ack = fetch accepted
- disp_rdata  out  DATA_WIDTH  fetched pixel
- disp_rvalid  out  1  one-cycle strobe, disp_rdata valid
- cpu_wvalid  in  1  CPU pixel write valid
- cpu_waddr  in  ADDR_WIDTH  CPU write address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_wready  out  1  FIFO not full
- wbuf_level  out  clog2(WBUF_DEPTH)+1  FIFO occupancy, 0..WBUF_DEPTH
- ram_en, ram_we  out  1  RAM enable / write enable (registered)
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_wdata  out  DATA_WIDTH  RAM write data (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data; 1-cycle read latency

## Operation
- At most one RAM access per cycle. The grant is decided combinationally in cycle N from inputs and registered state.
- Write FIFO:
  - Push on cpu_wvalid && cpu_wready.
  - cpu_wready = !full, and is 0 while in reset.
  - Pop only when the FIFO is non-empty at the start of the cycle. A word pushed into an empty FIFO can pop no earlier than the next cycle.
  - Push and pop in the same cycle leave the level unchanged. Push is blocked when full, even if a pop occurs that cycle.
- Grant rule:
  - disp_ack = disp_req && (fifo_empty || starve_cnt < STARVE_LIMIT).
  - Otherwise, if the FIFO is non-empty, pop its head as a CPU write.
  - Otherwise idle: ram_en = 0 next cycle.
- starve_cnt (8-bit):
  - +1 on each display grant while the FIFO is non-empty; saturates at STARVE_LIMIT.
  - Cleared on a CPU write grant.
  - Cleared on any cycle the FIFO is empty.
- No coherency: a display read of an address with a pending buffered write returns the old RAM data.
- FIFO writes retire in push order.
- Reset (asynchronous, any time):
  - FIFO emptied and contents discarded; starve_cnt = 0; in-flight reads dropped.
  - No disp_rvalid is generated for reads accepted before reset.

## Timing
- Reset values: disp_ack 0, disp_rdata 0, disp_rvalid 0, cpu_wready 0, wbuf_level 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Display read:
  - accepted in cycle N;
  - ram_en=1, ram_we=0, ram_addr=disp_addr in N+1;
  - ram_rdata captured at the end of N+2;
  - disp_rvalid=1 with disp_rdata in N+3.
  - Latency is 3 cycles, fully pipelined: one accept per cycle gives one rvalid per cycle, in order.
- CPU write:
  - popped in N;
  - ram_en=1, ram_we=1, ram_addr/ram_wdata = head entry in N+1.
  - Minimum push-to-RAM latency is 2 cycles.
- wbuf_level updates the cycle after the push/pop edge.
- FIFO pointer wrap at WBUF_DEPTH is seamless; full/empty are distinguished by an extra pointer bit.
- Continuous disp_req with a non-empty FIFO produces STARVE_LIMIT display grants, then 1 CPU grant, repeating.

## Test plan
- Display only: disp_req held for 10 cycles, addr 0x0000..0x0009, RAM returns addr as data -> 10 disp_ack cycles; disp_rvalid 10 consecutive cycles starting 3 cycles after the first accept, data 0x0000..0x0009 in order.
- CPU only: 4 back-to-back writes (0x0100, 0xF800)..(0x0103, 0x001F), disp_req=0 -> cpu_wready stays 1; 4 RAM writes with matching addr/data, first at push+2; wbuf_level returns to 0.
- FIFO full: disp_req held high with STARVE_LIMIT=8, push 5 writes with WBUF_DEPTH=4 -> cpu_wready=0 after the 4th push; 5th held until a pop; wbuf_level never exceeds 4; no write lost or reordered.
- Starvation: disp_req continuous with the FIFO holding 2 entries, STARVE_LIMIT=8 -> 8 display grants, 1 CPU write, 8 display grants, 1 CPU write; starve_cnt is 0 once the FIFO drains.
- Reset mid-operation: assert S_AXI_ARESETN=0 one cycle after a display accept, with 3 FIFO entries -> all outputs go to reset values immediately; no disp_rvalid afterward; wbuf_level=0; no RAM write from the old entries after release.
